// File: rtl/ef_smsdac_chk_if.sv
// Bus bundle between the segmented DAC loopback checker and its environment.
// Carries the reference sample, the four segment codes, the threshold and the
// per-window results (err_sum/err_valid/fail/win_cnt/busy).
interface ef_smsdac_chk_if #(
   parameter int LOG2_WIN = 4
);
   logic                           en;
   logic [7:0]                     d_ref;
   logic [1:0]                     d_out_3;
   logic [1:0]                     d_out_2;
   logic [1:0]                     d_out_1;
   logic [1:0]                     d_out_0;
   logic [15:0]                    thresh;
   logic signed [10+LOG2_WIN-1:0]  err_sum;
   logic                           err_valid;
   logic                           fail;
   logic [7:0]                     win_cnt;
   logic                           busy;

   // master: the environment driving the checker
   modport master (
      output en, d_ref, d_out_3, d_out_2, d_out_1, d_out_0, thresh,
      input  err_sum, err_valid, fail, win_cnt, busy
   );

   // slave: the checker itself
   modport slave (
      input  en, d_ref, d_out_3, d_out_2, d_out_1, d_out_0, thresh,
      output err_sum, err_valid, fail, win_cnt, busy
   );
endinterface

// File: rtl/ef_smsdac_chk.sv
// Loopback decoder/checker for the segmented mismatch-shaping DAC: rebuilds the
// analog level from the 8x/4x/2x/1x segment codes, sums it over 2^LOG2_WIN
// windows and compares against the LAT-delayed sum of the DAC's 8-bit input.
// Ports: clk, rst_b (sync, active-low), bus (slave modport: en, d_ref,
// d_out_3..0, thresh in; err_sum, err_valid, fail, win_cnt, busy out).
module ef_smsdac_chk #(
   parameter int LOG2_WIN = 4,
   parameter int LAT      = 2
) (
   input  logic               clk,
   input  logic               rst_b,
   ef_smsdac_chk_if.slave     bus
);
   localparam int EW = 10 + LOG2_WIN;           // err_sum width
   localparam int CW = (EW > 16) ? EW : 16;     // magnitude compare width

   typedef enum logic [1:0] {IDLE, FILL, ACC} state_t;

   state_t                    state;
   state_t                    state_nx;
   logic [7:0]                dly [LAT];
   logic [7:0]                d_dly;
   logic [3:0]                fill_cnt;
   logic [LOG2_WIN-1:0]       smp_cnt;
   logic [8+LOG2_WIN-1:0]     ref_acc;
   logic [9+LOG2_WIN-1:0]     out_acc;
   logic [1:0]                l3, l2, l1, l0;
   logic [8:0]                v16;
   logic [9+LOG2_WIN-1:0]     out_tot;
   logic [8+LOG2_WIN-1:0]     ref_tot;
   logic [EW-1:0]             diff;
   logic [EW-1:0]             diff_mag;
   logic                      over;
   logic                      close;
   logic                      busy;
   logic signed [EW-1:0]      err_sum;
   logic                      err_valid;
   logic                      fail;
   logic [7:0]                win_cnt;

   // Three-level segment: level is the number of set bits, so 01 and 10 both mean 1.
   function automatic logic [1:0] lvl(input logic [1:0] c);
      return {1'b0, c[1]} + {1'b0, c[0]};
   endfunction

   assign l3 = lvl(bus.d_out_3);
   assign l2 = lvl(bus.d_out_2);
   assign l1 = lvl(bus.d_out_1);
   assign l0 = lvl(bus.d_out_0);

   // v*16 with the weights folded into the shifts (8x16, 4x16, 2x16, 1x16).
   assign v16 = {l3, 7'd0} + {1'b0, l2, 6'd0} + {2'b0, l1, 5'd0} + {3'b0, l0, 4'd0};

   // Reference delay line; free-running so the data is valid once FILL ends.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         for (int i = 0; i < LAT; i++) dly[i] <= 8'd0;
      end else begin
         dly[0] <= bus.d_ref;
         for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      end
   end
   assign d_dly = dly[LAT-1];

   // Window totals including the current (last) sample.
   assign out_tot  = out_acc + {{LOG2_WIN{1'b0}}, v16};
   assign ref_tot  = ref_acc + {{LOG2_WIN{1'b0}}, d_dly};
   assign diff     = {1'b0, out_tot} - {2'b00, ref_tot};
   assign diff_mag = diff[EW-1] ? (~diff + 1'b1) : diff;
   assign over     = CW'(diff_mag) > CW'(bus.thresh);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      if (!bus.en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = FILL;
            FILL:    if (fill_cnt == 4'(LAT - 1)) state_nx = ACC;
            ACC:     state_nx = ACC;
            default: state_nx = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy  = (state != IDLE);
      // en low on the closing sample aborts the window rather than reporting it
      close = (state == ACC) && bus.en && (smp_cnt == '1);
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         fill_cnt  <= '0;
         smp_cnt   <= '0;
         ref_acc   <= '0;
         out_acc   <= '0;
         err_sum   <= '0;
         err_valid <= 1'b0;
         fail      <= 1'b0;
         win_cnt   <= '0;
      end else begin
         err_valid <= 1'b0;
         case (state)
            IDLE: begin
               fill_cnt <= '0;
               smp_cnt  <= '0;
               ref_acc  <= '0;
               out_acc  <= '0;
               if (bus.en) begin
                  fail    <= 1'b0;
                  win_cnt <= '0;
               end
            end
            FILL: begin
               fill_cnt <= fill_cnt + 4'd1;
            end
            ACC: begin
               if (close) begin
                  err_sum   <= diff;
                  err_valid <= 1'b1;
                  win_cnt   <= win_cnt + 8'd1;
                  fail      <= fail | over;
                  smp_cnt   <= '0;
                  ref_acc   <= '0;
                  out_acc   <= '0;
               end else begin
                  smp_cnt <= smp_cnt + 1'b1;
                  ref_acc <= ref_tot;
                  out_acc <= out_tot;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.err_sum   = err_sum;
   assign bus.err_valid = err_valid;
   assign bus.fail      = fail;
   assign bus.win_cnt   = win_cnt;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_ef_smsdac_chk.sv
// Directed bench for ef_smsdac_chk (LOG2_WIN=4, LAT=2): table of per-window
// vectors plus hand sequences for sticky fail, abort, reset and win_cnt wrap.
module tb_ef_smsdac_chk;
   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   ef_smsdac_chk_if #(.LOG2_WIN(4)) bus ();

   ef_smsdac_chk #(.LOG2_WIN(4), .LAT(2)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   always @(negedge clk) if (bus.err_valid === 1'b1) pulses++;

   typedef struct {
      string       name;
      logic [7:0]  d_ref;
      logic [1:0]  c3, c2, c1, c0;
      logic [15:0] th;
      int          exp_err;
      int          exp_fail;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Counts rising edges until err_valid is seen; -1 if the bound expires.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.err_valid !== 1'b1 && n < 100);
      if (bus.err_valid !== 1'b1) n = -1;
   endtask

   task automatic set_in(input vec_t v);
      bus.d_ref   = v.d_ref;
      bus.d_out_3 = v.c3;
      bus.d_out_2 = v.c2;
      bus.d_out_1 = v.c1;
      bus.d_out_0 = v.c0;
      bus.thresh  = v.th;
   endtask

   task automatic restart();
      bus.en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.en = 1'b1;
   endtask

   function automatic int err_i();
      return int'(bus.err_sum);
   endfunction

   initial begin
      int n;
      int p0;
      int bad;

      //           name        d_ref  c3     c2     c1     c0     thresh   err    fail
      tbl[0] = '{"matched",    8'h80, 2'b10, 2'b00, 2'b00, 2'b00, 16'd0,    0,     0};
      tbl[1] = '{"stuck",      8'h80, 2'b10, 2'b00, 2'b00, 2'b01, 16'd100,  256,   1};
      tbl[2] = '{"th_eq",      8'h80, 2'b10, 2'b00, 2'b00, 2'b01, 16'd256,  256,   0};
      tbl[3] = '{"th_below",   8'h80, 2'b10, 2'b00, 2'b00, 2'b01, 16'd255,  256,   1};
      tbl[4] = '{"full",       8'h00, 2'b11, 2'b11, 2'b11, 2'b11, 16'hFFFF, 7680,  0};
      tbl[5] = '{"neg_eq",     8'hFF, 2'b00, 2'b00, 2'b00, 2'b00, 16'd4080, -4080, 0};
      tbl[6] = '{"neg_over",   8'hFF, 2'b00, 2'b00, 2'b00, 2'b00, 16'd4079, -4080, 1};
      // v = 8*1 + 4*2 + 2*1 + 0 = 18 -> 288/sample vs 200 -> 88*16
      tbl[7] = '{"mixed",      8'hC8, 2'b01, 2'b11, 2'b10, 2'b00, 16'd1408, 1408,  0};

      bus.en = 1'b0;
      set_in(tbl[0]);
      rst_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_err_sum",   err_i(),       0);
      check("rst_err_valid", bus.err_valid, 0);
      check("rst_fail",      bus.fail,      0);
      check("rst_win_cnt",   bus.win_cnt,   0);
      check("rst_busy",      bus.busy,      0);
      rst_b = 1'b1;

      foreach (tbl[i]) begin
         set_in(tbl[i]);
         restart();
         @(posedge clk); #1;
         check({tbl[i].name, "_busy"}, bus.busy, 1);
         wait_valid(n);
         check({tbl[i].name, "_lat"},  n + 1,        19);
         check({tbl[i].name, "_err1"}, err_i(),      tbl[i].exp_err);
         check({tbl[i].name, "_fail"}, bus.fail,     tbl[i].exp_fail);
         check({tbl[i].name, "_win1"}, bus.win_cnt,  1);
         wait_valid(n);
         check({tbl[i].name, "_gap"},  n,            16);
         check({tbl[i].name, "_err2"}, err_i(),      tbl[i].exp_err);
         check({tbl[i].name, "_win2"}, bus.win_cnt,  2);
      end

      // Sticky fail survives the fault being released.
      set_in(tbl[1]);
      restart();
      wait_valid(n);
      check("stick_err", err_i(), 256);
      check("stick_fail", bus.fail, 1);
      bus.d_out_0 = 2'b00;
      wait_valid(n);
      check("release_err", err_i(), 0);
      check("release_fail", bus.fail, 1);

      // Abort after 7 accumulated samples of window 3.
      repeat (7) @(posedge clk);
      #1;
      bus.en = 1'b0;
      p0 = pulses;
      @(posedge clk); #1;
      check("abort_busy", bus.busy, 0);
      check("abort_fail_hold", bus.fail, 1);
      check("abort_win_hold", bus.win_cnt, 2);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_pulse", pulses, p0);
      bus.en = 1'b1;
      @(posedge clk); #1;
      check("restart_fail", bus.fail, 0);
      check("restart_win", bus.win_cnt, 0);
      check("restart_busy", bus.busy, 1);
      wait_valid(n);
      check("restart_lat", n + 1, 19);

      // Reset mid-window with fail set.
      bus.d_out_0 = 2'b01;
      wait_valid(n);
      check("prerst_fail", bus.fail, 1);
      repeat (5) @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(posedge clk); #1;
      check("mrst_err_sum",   err_i(),       0);
      check("mrst_err_valid", bus.err_valid, 0);
      check("mrst_fail",      bus.fail,      0);
      check("mrst_win_cnt",   bus.win_cnt,   0);
      check("mrst_busy",      bus.busy,      0);
      rst_b = 1'b1;
      @(posedge clk); #1;
      check("postrst_busy", bus.busy, 1);
      wait_valid(n);
      check("postrst_lat", n + 1, 19);
      check("postrst_err", err_i(), 256);

      // Full scale over 256 windows: win_cnt wraps 255 -> 0.
      set_in(tbl[4]);
      restart();
      bad = 0;
      for (int w = 1; w <= 256; w++) begin
         wait_valid(n);
         if (n < 0 || err_i() != 7680) bad++;
         if (w == 255) check("wrap_255", bus.win_cnt, 255);
         if (w == 256) check("wrap_0", bus.win_cnt, 0);
      end
      check("wrap_windows_bad", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ef_smsdac_chk.md
# ef_smsdac_chk

Loopback decoder and checker for the segmented mismatch-shaping DAC. It takes the four 2-bit three-level segment codes the DAC drives to its 8x/4x/2x/1x unit elements and reconstructs the analog level each cycle. It averages that level over fixed windows and compares the windowed sum against the windowed sum of the DAC's own 8-bit input, delayed to match the DAC's pipeline. It sits beside the DAC top level as an on-chip self-test monitor, and it reports a signed error per window plus a sticky fail flag.

## Interface

Parameters:
- LOG2_WIN, default 4: the window length is 2^LOG2_WIN samples. Legal range is 2..12.
- LAT, default 2: pipeline delay in cycles from the DAC's 8-bit input to its segment outputs. Legal range is 1..8.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_b  in  1  reset, synchronous and active-low.
- en  in  1  run enable. Low forces IDLE.
- d_ref  in  8  unsigned DAC input sample. Apply the same value, on the same cycle, that the DAC receives.
- d_out_3  in  2  8x-weight segment code.
- d_out_2  in  2  4x-weight segment code.
- d_out_1  in  2  2x-weight segment code.
- d_out_0  in  2  1x-weight segment code.
- thresh  in  16  unsigned error limit. Sampled when a window closes.
- err_sum  out  10+LOG2_WIN  signed error of the last window, computed as out_sum - ref_sum.
- err_valid  out  1  one-cycle pulse when err_sum updates.
- fail  out  1  sticky; set when |err_sum| > thresh.
- win_cnt  out  8  count of completed windows. Wraps from 255 to 0.
- busy  out  1  high whenever state is not IDLE.

## Operation

- Segment level: l_k = code[1] + code[0], range 0..2.
- Reconstructed value: v = 8*l3 + 4*l2 + 2*l1 + l0, range 0..30. Scaled output is v*16, range 0..480, 9 bits unsigned.
- Reference alignment: d_ref passes through a LAT-stage delay line, which always shifts. Sample n of d_ref is paired with the segment codes present LAT cycles later.
- Accumulators:
  - ref_acc: 8+LOG2_WIN bits unsigned, sums the delayed d_ref.
  - out_acc: 9+LOG2_WIN bits unsigned, sums v*16.
  - Neither accumulator can overflow at legal parameter values.
- FSM states:
  - IDLE: accumulators, sample counter and fill counter are held at 0. When en=1, go to FILL and clear fail and win_cnt.
  - FILL: wait LAT cycles so the delay line holds valid data, then go to ACC.
  - ACC: each cycle, add one sample to each accumulator and increment the LOG2_WIN-bit sample counter.
    - On the sample where the counter equals 2^LOG2_WIN-1, compute diff = (out_acc + v*16) - (ref_acc + d_ref_dly), sign-extended to 10+LOG2_WIN bits.
    - On that same cycle, register the results and reload: counter to 0, and both accumulators to 0. The next sample starts the new window, so windows are back to back with no gap. Stay in ACC.
  - In any state, en=0 sends the block to IDLE on the next edge.
- Window close, registered results:
  - err_sum <= diff.
  - err_valid <= 1.
  - win_cnt <= win_cnt + 1.
  - fail <= fail | (|diff| > thresh). The magnitude compare is zero-extended to 16 bits.
  - A value |diff| equal to thresh does not set fail.
- Abort: en dropping mid-window discards the partial window with no err_valid pulse. err_sum, fail and win_cnt hold their values while in IDLE.
- Inputs are not range-checked. Every code in 2'b00..2'b11 decodes by the level rule above.

## Timing

- Reset (rst_b=0 at an edge): state IDLE, and all outputs 0 (err_sum, err_valid, fail, win_cnt, busy). The delay line and accumulators are also 0. Reset overrides en.
- busy goes high on the edge after en is sampled high, and low on the edge after en is sampled low.
- First accumulated sample: the d_ref presented LAT cycles before the first ACC cycle. In practice, d_ref is presented on the cycle en is first sampled high, or earlier.
- err_valid pulses on the cycle after the last sample of a window. The next pulse follows exactly 2^LOG2_WIN cycles later.
- Latency from en sampled high to the first err_valid is 1 + LAT + 2^LOG2_WIN cycles.
- thresh is sampled only on window-close cycles.

## Test plan

- Matched DAC, LOG2_WIN=4, LAT=2:
  - Stimulus: d_ref=0x80 held; d_out_3=2'b10 and the other segments 2'b00.
  - Response: err_valid every 16 cycles, err_sum=0, fail=0, win_cnt incrementing 1, 2, 3.
- Stuck element:
  - Stimulus: same as the matched case, but d_out_0 forced to 2'b01 (v=9), thresh=100.
  - Response: err_sum=+256 and fail=1 after the first window. fail stays at 1 after d_out_0 is released.
- Threshold boundary:
  - Stimulus: same stuck fault with thresh=256.
  - Response: fail=0. Then set thresh=255 and fail=1 at the next window.
- Mid-window abort:
  - Stimulus: drop en after 7 ACC cycles, then raise it again.
  - Response: no err_valid for the partial window. busy falls one cycle after en falls. On restart, fail=0 and win_cnt=0, and the first err_valid arrives 1+LAT+16 cycles after en is sampled high.
- Reset mid-window:
  - Stimulus: rst_b=0 for one cycle during ACC with fail=1.
  - Response: all outputs 0 on the next edge. With en held high, the block re-enters FILL.
- Full scale and wrap:
  - Stimulus: all codes 2'b11 and d_ref=0x00.
  - Response: err_sum = 480*16 = +7680 every window. After 256 windows, win_cnt wraps 255 to 0.
